// File: rtl/jtag_tdo_mux_pkg.sv
// jtag_tdo_mux_pkg: shared TAP-flag decode, selection encoding and sizing helpers
// Contents: act_e (one action per cycle), flag bit positions, bypass_code(),
// decode_act() (priority decode), min_sel_w() (minimum DR_SEL width).
package jtag_tdo_mux_pkg;
    typedef enum logic [2:0] {ACT_NONE, ACT_CAP_IR, ACT_CAP_DR, ACT_SHIFT_IR, ACT_SHIFT_DR} act_e;
    // Bit positions of the TAP flags in the packed {cap_ir, cap_dr, shift_ir, shift_dr} word
    localparam int FLG_CAP_IR   = 3;
    localparam int FLG_CAP_DR   = 2;
    localparam int FLG_SHIFT_IR = 1;
    localparam int FLG_SHIFT_DR = 0;
    // The selection code one past the last data channel denotes the bypass register
    function automatic int bypass_code(input int n_chan);
        return n_chan;
    endfunction
    function automatic act_e decode_act(input logic [3:0] flags);
        return flags[FLG_CAP_IR]   ? ACT_CAP_IR   :
               flags[FLG_CAP_DR]   ? ACT_CAP_DR   :
               flags[FLG_SHIFT_IR] ? ACT_SHIFT_IR :
               flags[FLG_SHIFT_DR] ? ACT_SHIFT_DR : ACT_NONE;
    endfunction
    // Smallest width whose code space also holds the bypass code
    function automatic int min_sel_w(input int n_chan);
        int w;
        w = 1;
        while ((1 << w) <= n_chan) w++;
        return w;
    endfunction
endpackage

// File: rtl/jtag_tdo_mux_if.sv
// jtag_tdo_mux_if: TAP-side bus of the TDO output stage
// master: TAP controller / decoder side (drives flags, TDI, DR_SEL, register TDOs)
// slave:  TDO mux side (drives TDO, TDO_EN, BYPASS_ACT, SHIFT_CNT, PROTO_ERR)
interface jtag_tdo_mux_if #(
    parameter int N_CHAN = 4,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
);
    logic              capture_ir;
    logic              capture_dr;
    logic              shift_ir;
    logic              shift_dr;
    logic              tdi;
    logic [SEL_W-1:0]  dr_sel;
    logic [N_CHAN-1:0] dr_tdo;
    logic              ir_tdo;
    logic              tdo;
    logic              tdo_en;
    logic              bypass_act;
    logic [CNT_W-1:0]  shift_cnt;
    logic              proto_err;
    modport master (
        output capture_ir, capture_dr, shift_ir, shift_dr, tdi, dr_sel, dr_tdo, ir_tdo,
        input  tdo, tdo_en, bypass_act, shift_cnt, proto_err
    );
    modport slave (
        input  capture_ir, capture_dr, shift_ir, shift_dr, tdi, dr_sel, dr_tdo, ir_tdo,
        output tdo, tdo_en, bypass_act, shift_cnt, proto_err
    );
endinterface

// File: rtl/jtag_tdo_mux_bypass_reg.sv
// jtag_bypass_reg: 1-bit JTAG bypass register (capture to 0, shift from TDI, else hold)
// Ports: i_clk, i_rst (sync, active-high), i_capture, i_shift, i_tdi, o_q.
module jtag_bypass_reg (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_capture,
    input  logic i_shift,
    input  logic i_tdi,
    output logic o_q
);
    logic r_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_q <= 1'b0;
        else r_q <= i_capture ? 1'b0 : i_shift ? i_tdi : r_q;
    end
    assign o_q = r_q;
endmodule

// File: rtl/jtag_tdo_mux.sv
// jtag_tdo_mux: registered TDO output stage selecting IR, one of N_CHAN DRs, or bypass
// Ports: i_tck (retiming clock), i_reset (sync, active-high), bus (jtag_tdo_mux_if.slave)
// carrying the TAP flags, TDI, DR_SEL, DR_TDO, IR_TDO in and TDO, TDO_EN, BYPASS_ACT,
// SHIFT_CNT, PROTO_ERR out.
module jtag_tdo_mux
    import jtag_tdo_mux_pkg::*;
#(
    parameter int N_CHAN = 4,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic                 i_tck,
    input  logic                 i_reset,
    jtag_tdo_mux_if.slave        bus
);
    localparam logic [SEL_W-1:0] BYP = SEL_W'(bypass_code(N_CHAN));
    if (SEL_W < min_sel_w(N_CHAN)) begin : g_bad_sel_w
        $error("SEL_W too small for N_CHAN plus bypass code");
    end
    logic [3:0]           w_flags;
    act_e                 w_act;
    logic                 w_multi;
    logic                 w_bq;
    logic                 w_byp;
    logic [2**SEL_W-1:0]  w_dr;
    logic                 w_dr_bit;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_tdo;
    logic                 r_tdo_en;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    assign w_flags  = {bus.capture_ir, bus.capture_dr, bus.shift_ir, bus.shift_dr};
    assign w_act    = decode_act(w_flags);
    assign w_multi  = $countones(w_flags) > 1;
    assign w_byp    = r_sel == BYP;
    // Zero-pad so any SEL_W-bit code indexes in range; bypass never reads the pad
    assign w_dr     = {{(2**SEL_W-N_CHAN){1'b0}}, bus.dr_tdo};
    assign w_dr_bit = w_byp ? w_bq : w_dr[r_sel];
    jtag_bypass_reg u_bypass (
        .i_clk     (i_tck),
        .i_rst     (i_reset),
        .i_capture (w_act == ACT_CAP_DR),
        .i_shift   (w_act == ACT_SHIFT_DR),
        .i_tdi     (bus.tdi),
        .o_q       (w_bq)
    );
    always_ff @(posedge i_tck) begin
        if (i_reset) begin
            r_sel    <= BYP;
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err    <= r_err | w_multi;
            r_tdo_en <= w_act == ACT_SHIFT_IR || w_act == ACT_SHIFT_DR;
            r_tdo    <= w_act == ACT_SHIFT_IR ? bus.ir_tdo :
                        w_act == ACT_SHIFT_DR ? w_dr_bit : r_tdo;
            r_cnt    <= (w_act == ACT_CAP_IR || w_act == ACT_CAP_DR) ? '0 :
                        (w_act == ACT_SHIFT_IR || w_act == ACT_SHIFT_DR) && r_cnt != '1 ? r_cnt + CNT_W'(1) :
                        r_cnt;
            if (w_act == ACT_CAP_DR) r_sel <= bus.dr_sel < BYP ? bus.dr_sel : BYP;
        end
    end
    assign bus.tdo        = r_tdo;
    assign bus.tdo_en     = r_tdo_en;
    assign bus.bypass_act = w_byp;
    assign bus.shift_cnt  = r_cnt;
    assign bus.proto_err  = r_err;
endmodule

// File: tb/tb_jtag_tdo_mux.sv
// tb_jtag_tdo_mux: directed plus random stimulus against a behavioural TAP TDO model
module tb_jtag_tdo_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    jtag_tdo_mux_if #(.N_CHAN(4), .SEL_W(3), .CNT_W(8)) if8 ();
    jtag_tdo_mux_if #(.N_CHAN(4), .SEL_W(3), .CNT_W(2)) if2 ();
    jtag_tdo_mux #(.N_CHAN(4), .SEL_W(3), .CNT_W(8)) u_dut8 (.i_tck(clk), .i_reset(rst), .bus(if8.slave));
    jtag_tdo_mux #(.N_CHAN(4), .SEL_W(3), .CNT_W(2)) u_dut2 (.i_tck(clk), .i_reset(rst), .bus(if2.slave));
    assign if2.capture_ir = if8.capture_ir;
    assign if2.capture_dr = if8.capture_dr;
    assign if2.shift_ir   = if8.shift_ir;
    assign if2.shift_dr   = if8.shift_dr;
    assign if2.tdi        = if8.tdi;
    assign if2.dr_sel     = if8.dr_sel;
    assign if2.dr_tdo     = if8.dr_tdo;
    assign if2.ir_tdo     = if8.ir_tdo;
    // Reference state: selected channel (-1 = bypass), bypass bit, unbounded shift count
    int   m_sel = -1;
    int   m_cnt = 0;
    logic m_byp = 1'b0;
    logic m_tdo = 1'b0;
    logic m_en  = 1'b0;
    logic m_err = 1'b0;
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input logic r, input logic [3:0] f, input int sel, input logic tdi,
                       input logic [3:0] dr, input logic ir);
        rst = r;
        {if8.capture_ir, if8.capture_dr, if8.shift_ir, if8.shift_dr} = f;
        if8.dr_sel = 3'(sel);
        if8.tdi    = tdi;
        if8.dr_tdo = dr;
        if8.ir_tdo = ir;
        @(posedge clk);
        if (r) begin
            m_sel = -1; m_cnt = 0; m_byp = 0; m_tdo = 0; m_en = 0; m_err = 0;
        end else begin
            if (int'(f[0]) + int'(f[1]) + int'(f[2]) + int'(f[3]) > 1) m_err = 1;
            if (f[3]) begin
                m_cnt = 0; m_en = 0;
            end else if (f[2]) begin
                m_sel = sel < 4 ? sel : -1; m_byp = 0; m_cnt = 0; m_en = 0;
            end else if (f[1]) begin
                m_tdo = ir; m_en = 1; m_cnt++;
            end else if (f[0]) begin
                m_tdo = m_sel < 0 ? m_byp : dr[m_sel]; m_byp = tdi; m_en = 1; m_cnt++;
            end else m_en = 0;
        end
        #1;
        chk("tdo", if8.tdo, m_tdo);
        chk("tdo_en", if8.tdo_en, m_en);
        chk("bypass_act", if8.bypass_act, m_sel < 0);
        chk("shift_cnt8", if8.shift_cnt, m_cnt > 255 ? 255 : m_cnt);
        chk("proto_err", if8.proto_err, m_err);
        chk("tdo_w2", if2.tdo, m_tdo);
        chk("shift_cnt2", if2.shift_cnt, m_cnt > 3 ? 3 : m_cnt);
        chk("proto_err_w2", if2.proto_err, m_err);
    endtask
    initial begin
        logic [3:0] pat;
        logic [3:0] dr;
        int         p;
        int         cnt2_exp [6] = '{1, 2, 3, 3, 3, 3};
        // Reset with every flag raised
        cyc(1, 4'hF, 7, 1, 4'hF, 1);
        cyc(1, 4'hF, 7, 1, 4'hF, 1);
        chk("rst_tdo", if8.tdo, 0);
        chk("rst_en", if8.tdo_en, 0);
        chk("rst_cnt", if8.shift_cnt, 0);
        chk("rst_err", if8.proto_err, 0);
        chk("rst_byp", if8.bypass_act, 1);
        // Channel 2 select
        cyc(0, 4'b0100, 2, 0, 4'h0, 0);
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            dr = 4'($urandom);
            dr[2] = pat[i];
            cyc(0, 4'b0001, $urandom_range(0, 7), $urandom_range(0, 1), dr, 0);
            chk("ch2_tdo", if8.tdo, pat[i]);
            chk("ch2_en", if8.tdo_en, 1);
        end
        chk("ch2_cnt", if8.shift_cnt, 4);
        // Selection latched at capture, DR_SEL changed mid-shift
        cyc(0, 4'b0100, 1, 0, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            dr = 4'($urandom);
            cyc(0, 4'b0001, i < 2 ? 1 : 3, 0, dr, 0);
            chk("latch_tdo", if8.tdo, dr[1]);
        end
        chk("latch_byp", if8.bypass_act, 0);
        // Out-of-range select falls back to bypass
        cyc(0, 4'b0100, 5, 0, 4'h0, 0);
        chk("byp_act", if8.bypass_act, 1);
        pat = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 4'b0001, 2, i < 4 ? pat[i] : 1'b0, 4'hF, 0);
            chk("byp_tdo", if8.tdo, i == 0 ? 0 : pat[i-1]);
        end
        // IR path with narrow counter saturation
        cyc(0, 4'b1000, 0, 0, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 4'b0010, 0, 0, 4'hF, i % 2 == 0);
            chk("ir_tdo", if8.tdo, i % 2 == 0);
            chk("ir_cnt2", if2.shift_cnt, cnt2_exp[i]);
        end
        // Protocol error is sticky until reset
        cyc(0, 4'b0011, 0, 0, 4'h0, 1);
        chk("perr_set", if8.proto_err, 1);
        chk("perr_ir", if8.tdo, 1);
        cyc(0, 4'b0100, 0, 0, 4'h0, 0);
        cyc(0, 4'b0001, 0, 1, 4'h0, 0);
        cyc(0, 4'b0000, 0, 1, 4'h0, 0);
        chk("perr_hold", if8.proto_err, 1);
        cyc(1, 4'b0000, 0, 0, 4'h0, 0);
        chk("perr_clr", if8.proto_err, 0);
        // Random traffic, mostly legal with occasional overlaps and resets
        for (int i = 0; i < 600; i++) begin
            p = $urandom_range(0, 15);
            pat = p < 1 ? 4'b1000 : p < 3 ? 4'b0100 : p < 6 ? 4'b0010 :
                  p < 12 ? 4'b0001 : p < 14 ? 4'b0000 : 4'($urandom);
            cyc($urandom_range(0, 99) == 0, pat, $urandom_range(0, 7), $urandom_range(0, 1),
                4'($urandom), $urandom_range(0, 1));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/jtag_tdo_mux.md
Name: jtag_tdo_mux

Overview:
- Parametrised TDO output stage for the JTAG TAP.
- Selects between the instruction-register TDO and one of N_CHAN data-register TDOs, or an internal 1-bit bypass register.
- The data-register choice is latched at Capture-DR, so a DR_SEL change mid-shift has no effect.
- TDO and TDO_EN are registered for retiming; the block also keeps a shift-bit counter and a sticky TAP-protocol error flag for debug.

Parameters:
- N_CHAN, 4: number of data-register TDO inputs.
- SEL_W, 3: width of DR_SEL; must satisfy 2^SEL_W > N_CHAN.
- CNT_W, 8: width of the shift-bit counter.

Ports:
- TCK  input  1  retiming clock; all state updates on the rising edge; the top level connects inverted TCK for falling-edge TDO.
- RESET  input  1  synchronous, active-high reset.
- CAPTURE_IR  input  1  TAP in Capture-IR.
- CAPTURE_DR  input  1  TAP in Capture-DR.
- SHIFT_IR  input  1  TAP in Shift-IR.
- SHIFT_DR  input  1  TAP in Shift-DR.
- TDI  input  1  serial input; feeds the bypass register.
- DR_SEL  input  SEL_W  data-register index from the instruction decoder.
- DR_TDO  input  N_CHAN  serial output of each data register; bit i is channel i.
- IR_TDO  input  1  instruction-register serial output.
- TDO  output  1  registered serial output.
- TDO_EN  output  1  registered output enable; 1 only during shift.
- BYPASS_ACT  output  1  latched selection is the bypass register.
- SHIFT_CNT  output  CNT_W  bits shifted since the last capture; saturating.
- PROTO_ERR  output  1  sticky flag: illegal combination of TAP state flags.

Behaviour:
- Reset (RESET=1 at a clock edge) overrides all other inputs:
  - TDO=0, TDO_EN=0, SHIFT_CNT=0, PROTO_ERR=0.
  - Bypass register=0; latched selection=bypass, so BYPASS_ACT=1.
- Each cycle acts on exactly one flag, in priority order CAPTURE_IR > CAPTURE_DR > SHIFT_IR > SHIFT_DR.
- PROTO_ERR is set if more than one of the four flags is 1 in the same cycle. It stays set until RESET. The priority action above still executes.
- CAPTURE_IR:
  - SHIFT_CNT<=0; TDO_EN<=0; TDO holds.
  - Latched selection and bypass register unchanged.
- CAPTURE_DR:
  - Latched selection <= DR_SEL if DR_SEL < N_CHAN, otherwise bypass.
  - Bypass register <= 0; SHIFT_CNT<=0; TDO_EN<=0; TDO holds.
- SHIFT_IR:
  - TDO<=IR_TDO; TDO_EN<=1.
  - SHIFT_CNT increments and saturates at 2^CNT_W-1.
  - Bypass register unchanged.
- SHIFT_DR:
  - TDO <= DR_TDO[latched index], or the current bypass register value if bypass is latched.
  - Bypass register <= TDI, every SHIFT_DR cycle regardless of selection.
  - TDO_EN<=1; SHIFT_CNT increments and saturates.
- No flag set: TDO_EN<=0; TDO, SHIFT_CNT, latched selection and bypass register all hold.
- Latency:
  - TDO shows the source value sampled one clock earlier.
  - In bypass, TDI reaches TDO two clocks after it is sampled: bypass register, then TDO register.
- DR_SEL is ignored in every cycle except CAPTURE_DR.
- A SHIFT_DR with no prior CAPTURE_DR since reset shifts through the bypass register.
- BYPASS_ACT is a direct decode of the latched selection.

Decomposition:
- Shared jtag package holds:
  - Selection encoding constant: bypass code = N_CHAN.
  - Flag-priority helper constants.
  - Function computing the minimum SEL_W from N_CHAN, used in an elaboration-time check.
- One natural sub-module, jtag_bypass_reg: the 1-bit bypass register, with capture-to-0, shift and hold behaviour.
- Selection latch, TDO register, counter and error flag stay in the top module.

Test Plan:
- Reset: assert RESET for 2 cycles with all flags set -> TDO=0, TDO_EN=0, SHIFT_CNT=0, PROTO_ERR=0, BYPASS_ACT=1.
- Channel select:
  - Setup: N_CHAN=4; CAPTURE_DR with DR_SEL=2; then 4 SHIFT_DR cycles with DR_TDO[2]=1,0,1,1.
  - Required: TDO=1,0,1,1 one cycle late; TDO_EN=1 during those cycles; SHIFT_CNT=4.
- Selection latching:
  - Setup: CAPTURE_DR with DR_SEL=1; change DR_SEL to 3 mid-shift.
  - Required: TDO keeps following DR_TDO[1]; BYPASS_ACT=0.
- Bypass:
  - Setup: CAPTURE_DR with DR_SEL=5 (≥N_CHAN); SHIFT_DR with TDI=1,0,1,1.
  - Required: BYPASS_ACT=1; TDO=0,1,0,1 in shift cycles 2..5 (captured 0 first, then TDI delayed).
- IR path and saturation:
  - Setup: CNT_W=2; CAPTURE_IR then 6 SHIFT_IR cycles with IR_TDO toggling.
  - Required: TDO follows IR_TDO one cycle late; SHIFT_CNT=1,2,3,3,3,3.
- Protocol error:
  - Setup: SHIFT_IR=1 and SHIFT_DR=1 in one cycle; then a legal sequence; then RESET.
  - Required: PROTO_ERR=1 from the next edge; IR action taken; PROTO_ERR stays 1 until RESET clears it.
